fdiv_controller: RTL
====================

# fdiv_controller

Control FSM for the clock-measurement/divider datapath. It sits directly upstream of the datapath and drives its `LdCnt` and `counten` strobes. It waits for the datapath's `kcalc` flag, loads the half-period counter from `k`, runs it, and reloads on every `cout`. It also resynchronises when the divide select `n` changes, stalls on degenerate `k`, and reports lock and watchdog status.

## Interface
- `WD_W`, default 16: watchdog counter width; timeout fires after 2^WD_W−1 cycles in WAIT_K.
- `ref_clk`, in, 1: sole clock; all state updates on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: run enable; 0 forces IDLE from any state.
- `kcalc`, in, 1: datapath measurement-valid flag; sticky high once set.
- `k`, in, 8: datapath divide value; half-period reload is `k>>1`.
- `n`, in, 3: divide select, same bus the datapath uses.
- `cout`, in, 1: datapath terminal count (`cnt==255`).
- `LdCnt`, out, 1: parallel-load strobe to datapath counter.
- `counten`, out, 1: count enable to datapath counter.
- `locked`, out, 1: high once a full half-period has completed in RUN.
- `err_timeout`, out, 1: watchdog expiry, sticky until `rst`.

## Operation
- States: IDLE, WAIT_K, LOAD, RUN, STALL.
- Outputs by state (Mealy):
  - IDLE: `LdCnt=0`, `counten=0`.
  - WAIT_K: `LdCnt=0`, `counten=0`.
  - LOAD: `LdCnt=1`, `counten=0`.
  - STALL: `LdCnt=0`, `counten=0`.
  - RUN: `LdCnt=cout`, `counten=~cout`.
- Transitions, evaluated in priority order:
  - `en==0` → IDLE from any state.
  - IDLE → WAIT_K when `en==1`.
  - WAIT_K → LOAD when `kcalc==1`.
  - LOAD → STALL if `k<2`, else → RUN.
  - STALL → LOAD when `k>=2`.
  - RUN → LOAD when `n != n_q`. This is a resync; the `cout` reload is suppressed that cycle.
  - Otherwise, RUN stays in RUN. A `cout` in RUN reloads in place through the Mealy `LdCnt`.
- `n_q`: register holding `n`. Updated every cycle in LOAD; held in all other states.
- `locked`:
  - Set on the first `cout==1` seen in RUN.
  - Cleared on entry to LOAD from RUN (n change), on entry to STALL, IDLE or WAIT_K, and by `rst`.
  - An in-place `cout` reload keeps it set.
- Degenerate `k` (0 or 1): the datapath would hold `cout` high permanently and the TFF would never toggle. The controller therefore parks in STALL with the counter idle.
- Half-period produced in RUN is `(k>>1)+1` `ref_clk` cycles: `k>>1` count cycles plus one reload cycle.

## Timing
- Reset (`rst=1` at a posedge):
  - Next state is IDLE.
  - `LdCnt=0`, `counten=0`, `locked=0`, `err_timeout=0`.
  - `n_q=0`; watchdog count = 0.
  - Applies mid-operation in any state, with no partial update.
- Latencies:
  - `en` rising: 1 cycle to WAIT_K.
  - `kcalc` seen in WAIT_K: LOAD on the next cycle; `LdCnt` high for exactly 1 cycle.
  - RUN begins the cycle after LOAD; the first `counten` is in that cycle.
- `cout` and `n` change in the same cycle: the n change wins. The next state is LOAD, `LdCnt` is still 1 this cycle, and `locked` drops the next cycle.
- `en=0` in the same cycle as anything else: IDLE next cycle.
  - Outputs this cycle still follow the current state's table.
  - The datapath counter keeps its value.
- `LdCnt` and `counten` are never both 1 in the same cycle.

## Configuration
- `FDIV_WATCHDOG_EN` defined:
  - A WD_W-bit counter increments each cycle in WAIT_K and clears on leaving WAIT_K.
  - On reaching all-ones it sets `err_timeout`, which is sticky until `rst`.
  - The FSM stays in WAIT_K and still honours a later `kcalc`.
- `FDIV_WATCHDOG_EN` not defined:
  - No watchdog counter.
  - `err_timeout` tied to 0; `WD_W` is unused.

## Test plan
- Reset, then `en=1`, `kcalc=1`, `k=8`:
  - `LdCnt` pulses once 2 cycles after `en`.
  - `counten` is high 4 cycles, then `LdCnt` with `cout`, repeating every 5 cycles.
  - `locked` rises after the first `cout`.
- In RUN with `k=8`, change `n` from 1 to 2 in the same cycle as `cout`:
  - Next cycle is LOAD with `LdCnt=1`.
  - `locked` drops, then re-locks after the next `cout`.
- `k=1` at LOAD → STALL with both strobes 0 and `locked=0`. Raise `k` to 6 → LOAD, then RUN with a 4-cycle half-period.
- `en=1` with `kcalc` held 0, `WD_W=4`, macro defined:
  - `err_timeout` rises after 15 cycles in WAIT_K and stays high after `kcalc=1`.
  - With the macro undefined it stays 0.
- Assert `rst` for 1 cycle mid-RUN → all outputs 0 next cycle and state IDLE. Deassert `en` mid-RUN → IDLE and `counten=0` next cycle.

Source files
------------

// File: rtl/fdiv_controller.sv
// -----------------------------------------------------------------------------
// fdiv_controller
//
// Control FSM for the clock-measurement / divider datapath. It waits for the
// datapath's measurement-valid flag, loads the half-period counter with k,
// lets it run, and reloads it on every terminal count. A change of the divide
// select n forces a resynchronising reload. A degenerate k (0 or 1) parks the
// controller with the counter idle. Lock and watchdog status are reported.
//
// Ports
//   ref_clk      in   1  sole clock, all state updates on posedge
//   rst          in   1  synchronous, active-high reset
//   en           in   1  run enable; low forces IDLE from any state
//   kcalc        in   1  datapath measurement-valid flag (sticky once set)
//   k            in   8  datapath divide value; half-period reload is k>>1
//   n            in   3  divide select, shared with the datapath
//   cout         in   1  datapath terminal count (cnt == 255)
//   LdCnt        out  1  parallel-load strobe to the datapath counter
//   counten      out  1  count enable to the datapath counter
//   locked       out  1  high once a full half-period has completed in RUN
//   err_timeout  out  1  watchdog expiry, sticky until rst
//
// Parameters
//   WD_W  watchdog counter width (>= 2); timeout after 2^WD_W-1 WAIT_K cycles
//
// Configuration macro
//   FDIV_WATCHDOG_EN  defined   : WAIT_K watchdog present, drives err_timeout
//                     undefined : no watchdog, err_timeout tied to 0
//
// LdCnt and counten are Mealy outputs: in RUN they follow cout directly so a
// terminal count reloads the counter in place without leaving RUN. The two
// strobes are mutually exclusive in every state.
// -----------------------------------------------------------------------------
module fdiv_controller #(
    parameter int unsigned WD_W = 16
) (
    input  logic       ref_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       kcalc,
    input  logic [7:0] k,
    input  logic [2:0] n,
    input  logic       cout,
    output logic       LdCnt,
    output logic       counten,
    output logic       locked,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_K,
        LOAD,
        RUN,
        STALL
    } state_t;

    state_t     state;
    logic [2:0] n_q;

    // k of 0 or 1 would leave cout stuck high in the datapath.
    logic k_ok;
    logic n_changed;

    assign k_ok      = (k >= 8'd2);
    assign n_changed = (n != n_q);

    // -------------------------------------------------------------------------
    // Mealy strobes. In RUN a terminal count turns the enable into a load,
    // which is what makes the half-period k>>1 count cycles plus one reload.
    // -------------------------------------------------------------------------
    assign LdCnt   = (state == LOAD) || ((state == RUN) && cout);
    assign counten = (state == RUN) && !cout;

    // -------------------------------------------------------------------------
    // State, n_q and locked.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: reset is synchronous (sampled inside the clocked block) and takes
    // priority over every other update, so no partial update leaks through.
    // -------------------------------------------------------------------------
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state  <= IDLE;
            n_q    <= 3'd0;
            locked <= 1'b0;
        end else begin
            // n_q tracks n for the whole LOAD cycle; RUN compares against it.
            if (state == LOAD) begin
                n_q <= n;
            end

            if (!en) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= WAIT_K;
                        locked <= 1'b0;
                    end

                    WAIT_K: begin
                        if (kcalc) begin
                            state <= LOAD;
                        end
                    end

                    LOAD: begin
                        if (k_ok) begin
                            state <= RUN;
                        end else begin
                            state  <= STALL;
                            locked <= 1'b0;
                        end
                    end

                    STALL: begin
                        if (k_ok) begin
                            state <= LOAD;
                        end
                    end

                    RUN: begin
                        // A divide-select change outranks a coincident cout:
                        // the in-place reload still strobes this cycle, but
                        // the lock is dropped and a full LOAD follows.
                        if (n_changed) begin
                            state  <= LOAD;
                            locked <= 1'b0;
                        end else if (cout) begin
                            locked <= 1'b1;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // WAIT_K watchdog.
    // -------------------------------------------------------------------------
`ifdef FDIV_WATCHDOG_EN
    localparam logic [WD_W-1:0] WD_MAX = '1;
    localparam logic [WD_W-1:0] WD_PRE = {{(WD_W-1){1'b1}}, 1'b0};
    localparam logic [WD_W-1:0] WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wd_cnt;

    // The count saturates at all-ones; the flag is set on the edge where the
    // count reaches all-ones, i.e. after 2^WD_W-1 consecutive WAIT_K cycles.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (state == WAIT_K) begin
            if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end
            if (wd_cnt == WD_PRE) begin
                err_timeout <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    // Watchdog absent: constant 0. WD_W is referenced only so the parameter
    // remains part of the interface in this build.
    assign err_timeout = 1'b0 & (WD_W != 0);
`endif

endmodule
